// File: rtl/idex_stage_reg.sv
// ============================================================================
//  Module   : idex_stage_reg
//  Brief    : ID/EX pipeline register with load-use hazard detection, WB
//             bypass, flush/stall handling and a saturating bubble counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module idex_stage_reg #(
   parameter int DATA_W = 16,
   parameter int RA_W   = 4,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_op1,
   input  logic [DATA_W-1:0] id_op2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_mem_read,
   input  logic              id_reg_write,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              IDEX_valid,
   output logic [DATA_W-1:0] IDEX_op1,
   output logic [DATA_W-1:0] IDEX_op2,
   output logic [DATA_W-1:0] IDEX_imm,
   output logic [RA_W-1:0]   IDEX_rs1,
   output logic [RA_W-1:0]   IDEX_rs2,
   output logic [RA_W-1:0]   IDEX_rd,
   output logic [CTRL_W-1:0] IDEX_ctrl,
   output logic              IDEX_mem_read,
   output logic              IDEX_reg_write,
   output logic              pc_write,
   output logic              ifid_write,
   output logic [15:0]       bubble_cnt
);

   localparam logic [15:0] c_cnt_max = 16'hFFFF;

   logic w_hazard;
   logic w_bubble;
   logic w_load;
   logic w_byp1;
   logic w_byp2;

   // Load-use: the load now in EX produces a register the ID instruction reads.
   assign w_hazard = id_valid & IDEX_valid & IDEX_mem_read &
                     ((IDEX_rd == id_rs1) | (IDEX_rd == id_rs2));

   assign pc_write   = ~(ext_stall | w_hazard);
   assign ifid_write = ~(ext_stall | w_hazard);

   // Flush wins over stall; a stall suppresses the hazard bubble until released.
   assign w_bubble = flush | (~ext_stall & w_hazard);
   assign w_load   = ~flush & ~ext_stall & ~w_hazard;

   assign w_byp1 = wb_en & (wb_rd == id_rs1);
   assign w_byp2 = wb_en & (wb_rd == id_rs2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IDEX_valid     <= 1'b0;
         IDEX_op1       <= '0;
         IDEX_op2       <= '0;
         IDEX_imm       <= '0;
         IDEX_rs1       <= '0;
         IDEX_rs2       <= '0;
         IDEX_rd        <= '0;
         IDEX_ctrl      <= '0;
         IDEX_mem_read  <= 1'b0;
         IDEX_reg_write <= 1'b0;
         bubble_cnt     <= 16'd0;
      end else begin
         if (w_bubble && (bubble_cnt != c_cnt_max)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end
         if (w_bubble) begin
            // Addresses cleared too so the forwarding unit never matches stale state.
            IDEX_valid     <= 1'b0;
            IDEX_op1       <= '0;
            IDEX_op2       <= '0;
            IDEX_imm       <= '0;
            IDEX_rs1       <= '0;
            IDEX_rs2       <= '0;
            IDEX_rd        <= '0;
            IDEX_ctrl      <= '0;
            IDEX_mem_read  <= 1'b0;
            IDEX_reg_write <= 1'b0;
         end else if (w_load) begin
            IDEX_valid     <= id_valid;
            IDEX_op1       <= w_byp1 ? wb_data : id_op1;
            IDEX_op2       <= w_byp2 ? wb_data : id_op2;
            IDEX_imm       <= id_imm;
            IDEX_rs1       <= id_rs1;
            IDEX_rs2       <= id_rs2;
            IDEX_rd        <= id_rd;
            IDEX_ctrl      <= id_ctrl;
            IDEX_mem_read  <= id_mem_read;
            IDEX_reg_write <= id_reg_write;
         end
      end
   end

endmodule

`default_nettype wire
